// File: rtl/wr_ddr_burst_ctrl.sv
// Read-side burst scheduler: drains the write-to-DDR FIFO into fixed-length
// AXI4 INCR write bursts whose start address walks a wrapping frame region.
module wr_ddr_burst_ctrl #(
  parameter int unsigned           ADDR_WIDTH  = 28,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           LEVEL_WIDTH = 11,
  parameter int unsigned           BURST_LEN   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           FRAME_BYTES = 32'h0007_E900
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic                   enable,
  input  logic                   frame_sync,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic [ADDR_WIDTH-1:0]  m_awaddr,
  output logic [7:0]             m_awlen,
  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [DATA_WIDTH-1:0]  m_wdata,
  output logic                   m_wvalid,
  input  logic                   m_wready,
  output logic                   m_wlast,
  input  logic                   m_bvalid,
  input  logic [1:0]             m_bresp,
  output logic                   m_bready,
  output logic                   busy,
  output logic                   burst_done,
  output logic                   resp_err
);

  localparam int unsigned         BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] ADDR_STEP   = (ADDR_WIDTH + 1)'(BURST_BYTES);
  localparam logic [ADDR_WIDTH:0] REGION_END  = {1'b0, BASE_ADDR} + (ADDR_WIDTH + 1)'(FRAME_BYTES);
  localparam logic [8:0]          LEN_W       = 9'(BURST_LEN);
  localparam logic [7:0]          LAST_BEAT   = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  state_t                  state_reg, state_next;
  logic [8:0]              words_read_reg;
  logic [7:0]              beat_reg;
  logic                    rd_pending_reg;
  logic [1:0]              skid_count_reg;
  logic [DATA_WIDTH-1:0]   skid_reg [2];
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    sync_latch_reg;
  logic                    resp_err_reg;

  logic                    push;
  logic                    pop;
  logic                    wr_sel;
  logic [ADDR_WIDTH:0]     addr_inc;

  assign m_awaddr = addr_reg;
  assign m_awlen  = LAST_BEAT;
  assign m_wdata  = skid_reg[0];
  assign resp_err = resp_err_reg;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_wlast    = 1'b0;
    m_bready   = 1'b0;
    busy       = 1'b1;
    burst_done = 1'b0;
    fifo_rd_en = 1'b0;
    unique case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (enable && (32'(fifo_rd_water_level) >= BURST_LEN)) state_next = AW;
      end
      AW: begin
        m_awvalid = 1'b1;
        if (m_awready) state_next = W;
      end
      W: begin
        m_wvalid = (skid_count_reg != 2'd0);
        m_wlast  = m_wvalid && (beat_reg == LAST_BEAT);
        if (m_wvalid && m_wready && m_wlast) state_next = B;
      end
      B: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          burst_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Reads overlap the address phase; the in-flight read reserves its skid slot.
    if ((state_reg == AW) || (state_reg == W))
      fifo_rd_en = (words_read_reg < LEN_W) && !fifo_rd_empty &&
                   ((skid_count_reg + {1'b0, rd_pending_reg}) < 2'd2);
  end

  assign pop    = m_wvalid && m_wready;
  assign push   = rd_pending_reg;
  assign wr_sel = (skid_count_reg == 2'd2) || ((skid_count_reg == 2'd1) && !pop);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      words_read_reg <= '0;
      beat_reg       <= '0;
      rd_pending_reg <= 1'b0;
      skid_count_reg <= '0;
    end else begin
      rd_pending_reg <= fifo_rd_en;
      skid_count_reg <= skid_count_reg + {1'b0, push} - {1'b0, pop};
      if (state_reg == IDLE) begin
        words_read_reg <= '0;
        beat_reg       <= '0;
      end else begin
        if (fifo_rd_en) words_read_reg <= words_read_reg + 9'd1;
        if (pop)        beat_reg       <= beat_reg + 8'd1;
      end
    end
  end

  // Entry 0 is always the head; a pop shifts entry 1 down before the new word lands.
  always_ff @(posedge rd_clk) begin
    if (pop)  skid_reg[0]      <= skid_reg[1];
    if (push) skid_reg[wr_sel] <= fifo_rd_data;
  end

  assign addr_inc = {1'b0, addr_reg} + ADDR_STEP;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      addr_reg       <= BASE_ADDR;
      sync_latch_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (frame_sync) addr_reg <= BASE_ADDR;
    end else if (burst_done) begin
      if (sync_latch_reg || frame_sync || (addr_inc >= REGION_END)) addr_reg <= BASE_ADDR;
      else                                                          addr_reg <= addr_inc[ADDR_WIDTH-1:0];
      sync_latch_reg <= 1'b0;
      if (m_bresp != 2'b00) resp_err_reg <= 1'b1;
    end else if (frame_sync) begin
      sync_latch_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wr_ddr_burst_ctrl.sv
// Bench for wr_ddr_burst_ctrl: FIFO model plus AXI write slave; a 192-byte
// frame region (three bursts) so both wrap and frame_sync restarts are visible.
module tb_wr_ddr_burst_ctrl;
  localparam int BL = 16;
  localparam int FB = 192;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, enable = 1'b0, frame_sync = 1'b0;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_rd_empty = 1'b1;
  logic [10:0] fifo_level = '0;
  logic [27:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic        m_awvalid, m_wvalid, m_wlast, m_bready, busy, burst_done, resp_err;
  logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
  logic [1:0]  m_bresp = 2'b00;
  logic [31:0] m_wdata;

  wr_ddr_burst_ctrl #(.FRAME_BYTES(FB)) dut (
    .rd_clk(clk), .rd_rst(rst), .enable(enable), .frame_sync(frame_sync),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_water_level(fifo_level),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .busy(busy), .burst_done(burst_done), .resp_err(resp_err)
  );

  int passed = 0, total = 0;

  // Scoreboard: expectations pushed at stimulus time, observations pushed by the monitor.
  logic [31:0] fifo_q[$];
  logic [31:0] exp_w[$], obs_w[$];
  logic [27:0] exp_aw[$], obs_aw[$];
  logic [7:0]  obs_len[$];
  logic [31:0] word_ctr = 0;

  int  aw_delay = 0, aw_wait = 0;
  bit  rand_wready = 0, b_pend = 0, w_stall = 0, aw_stall = 0;
  logic [1:0]  bresp_val = 2'b00;
  logic [31:0] prev_wdata = '0;
  logic [27:0] last_aw = '0;
  int  beat_idx = 0, rd_en_cnt = 0, done_cnt = 0, proto_err = 0, wlast_err = 0, underflow = 0;

  // FIFO read side: data appears the cycle after fifo_rd_en.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
      else underflow++;
    end
    fifo_rd_empty <= (fifo_q.size() == 0);
    fifo_level    <= 11'(fifo_q.size());
  end

  // AXI slave + monitor: drive at negedge, observe the handshakes of the next edge at negedge+1.
  always @(negedge clk) begin
    m_awready = m_awvalid && (aw_wait >= aw_delay);
    m_wready  = rand_wready ? 1'($urandom_range(0, 1)) : 1'b1;
    m_bvalid  = b_pend;
    m_bresp   = b_pend ? bresp_val : 2'b00;
    #1;
    if (rst) begin
      aw_wait = 0; b_pend = 0; w_stall = 0; aw_stall = 0; beat_idx = 0;
    end else begin
      if (aw_stall && !m_awvalid) proto_err++;
      if (w_stall && (!m_wvalid || m_wdata !== prev_wdata)) proto_err++;
      aw_stall   = m_awvalid && !m_awready;
      w_stall    = m_wvalid && !m_wready;
      prev_wdata = m_wdata;
      if (m_awvalid) begin
        if (m_awready) begin
          obs_aw.push_back(m_awaddr); obs_len.push_back(m_awlen);
          last_aw = m_awaddr; aw_wait = 0;
        end else aw_wait++;
      end
      if (m_wvalid && m_wready) begin
        obs_w.push_back(m_wdata);
        if (m_wlast != (beat_idx == BL - 1)) wlast_err++;
        if (m_wlast) begin b_pend = 1; beat_idx = 0; end
        else beat_idx++;
      end
      if (fifo_rd_en) rd_en_cnt++;
      if (burst_done) begin
        done_cnt++;
        $display("burst addr=%h bresp=%0d beats_seen=%0d", last_aw, m_bresp, obs_w.size());
      end
      if (m_bvalid && m_bready) b_pend = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #2; end
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(word_ctr); exp_w.push_back(word_ctr); word_ctr++;
    end
  endtask

  task automatic clear_obs();
    obs_w.delete(); obs_aw.delete(); obs_len.delete();
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      tick(1);
      if (done_cnt >= target) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    tick(3);
    v = {fifo_rd_en, m_awvalid, m_wvalid, m_wlast, m_bready, busy, burst_done, resp_err};
    total++; if (v !== 8'h00) $display("FAIL reset_outputs: got %b want 00000000", v); else passed++;
    total++; if (m_awaddr !== 28'h0) $display("FAIL reset_awaddr: got %h want 0", m_awaddr); else passed++;
    total++; if (m_awlen !== 8'd15) $display("FAIL reset_awlen: got %0d want 15", m_awlen); else passed++;
    rst = 0; tick(1);
  endtask

  task automatic test_single_burst();
    int d0, r0; bit ok; logic [31:0] e, o; logic [27:0] ea, oa;
    clear_obs(); d0 = done_cnt; r0 = rd_en_cnt;
    exp_aw.push_back(28'h0); fill(BL); enable = 1;
    wait_done(d0 + 1, ok); tick(5);
    total++; if (ok !== 1'b1) $display("FAIL single_timeout: got %0d want 1", ok); else passed++;
    ea = exp_aw.pop_front(); oa = (obs_aw.size() > 0) ? obs_aw[0] : 28'hFFFFFFF;
    total++; if (oa !== ea) $display("FAIL single_awaddr: got %h want %h", oa, ea); else passed++;
    total++; if (obs_len.size() == 0 || obs_len[0] !== 8'd15) $display("FAIL single_awlen: got %p want 15", obs_len); else passed++;
    for (int i = 0; i < BL; i++) begin
      e = exp_w.pop_front(); o = 32'hDEADBEEF;
      if (obs_w.size() > 0) o = obs_w.pop_front();
      total++; if (o !== e) $display("FAIL single_wdata[%0d]: got %h want %h", i, o, e); else passed++;
    end
    total++; if (done_cnt - d0 !== 1) $display("FAIL single_done_count: got %0d want 1", done_cnt - d0); else passed++;
    total++; if (rd_en_cnt - r0 !== BL) $display("FAIL single_rd_en_count: got %0d want %0d", rd_en_cnt - r0, BL); else passed++;
    total++; if (wlast_err !== 0) $display("FAIL single_wlast: got %0d bad beats want 0", wlast_err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL single_idle_after: got busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_random_stall();
    int d0; bit ok; logic [31:0] e, o;
    clear_obs(); d0 = done_cnt; aw_delay = 5; rand_wready = 1;
    exp_aw.push_back(28'h40); fill(BL);
    wait_done(d0 + 1, ok); tick(5);
    total++; if (ok !== 1'b1) $display("FAIL stall_timeout: got %0d want 1", ok); else passed++;
    total++; if (obs_aw.size() != 1 || obs_aw[0] !== exp_aw[0]) $display("FAIL stall_awaddr: got %p want %h", obs_aw, exp_aw[0]); else passed++;
    void'(exp_aw.pop_front());
    for (int i = 0; i < BL; i++) begin
      e = exp_w.pop_front(); o = 32'hDEADBEEF;
      if (obs_w.size() > 0) o = obs_w.pop_front();
      total++; if (o !== e) $display("FAIL stall_wdata[%0d]: got %h want %h", i, o, e); else passed++;
    end
    total++; if (obs_w.size() != 0) $display("FAIL stall_extra_beats: got %0d want 0", obs_w.size()); else passed++;
    total++; if (proto_err !== 0) $display("FAIL stall_valid_drop: got %0d want 0", proto_err); else passed++;
    aw_delay = 0; rand_wready = 0;
  endtask

  task automatic test_wrap();
    int d0; bit ok; logic [31:0] e, o; logic [27:0] ea, oa;
    clear_obs(); d0 = done_cnt;
    exp_aw.push_back(28'h80); exp_aw.push_back(28'h00); exp_aw.push_back(28'h40);
    fill(3 * BL);
    wait_done(d0 + 3, ok); tick(5);
    total++; if (ok !== 1'b1) $display("FAIL wrap_timeout: got %0d want 1", ok); else passed++;
    for (int i = 0; i < 3; i++) begin
      ea = exp_aw.pop_front(); oa = 28'hFFFFFFF;
      if (obs_aw.size() > 0) oa = obs_aw.pop_front();
      total++; if (oa !== ea) $display("FAIL wrap_awaddr[%0d]: got %h want %h", i, oa, ea); else passed++;
    end
    for (int i = 0; i < 3 * BL; i++) begin
      e = exp_w.pop_front(); o = 32'hDEADBEEF;
      if (obs_w.size() > 0) o = obs_w.pop_front();
      total++; if (o !== e) $display("FAIL wrap_wdata[%0d]: got %h want %h", i, o, e); else passed++;
    end
  endtask

  task automatic test_frame_sync();
    int d0; bit ok, seen; logic [31:0] e, o; logic [27:0] ea, oa;
    clear_obs();
    frame_sync = 1; tick(1); frame_sync = 0;
    total++; if (m_awaddr !== 28'h0) $display("FAIL sync_idle_addr: got %h want 0", m_awaddr); else passed++;
    d0 = done_cnt;
    exp_aw.push_back(28'h00); fill(BL);
    wait_done(d0 + 1, ok); tick(2);
    exp_aw.push_back(28'h40); fill(BL);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin tick(1); seen = m_wvalid; end
    total++; if (seen !== 1'b1) $display("FAIL sync_w_timeout: got %0d want 1", seen); else passed++;
    frame_sync = 1; tick(1); frame_sync = 0; tick(2);
    frame_sync = 1; tick(1); frame_sync = 0;
    wait_done(d0 + 2, ok); tick(3);
    total++; if (ok !== 1'b1) $display("FAIL sync_timeout: got %0d want 1", ok); else passed++;
    total++; if (m_awaddr !== 28'h0) $display("FAIL sync_restart_addr: got %h want 0", m_awaddr); else passed++;
    for (int i = 0; i < 2; i++) begin
      ea = exp_aw.pop_front(); oa = 28'hFFFFFFF;
      if (obs_aw.size() > 0) oa = obs_aw.pop_front();
      total++; if (oa !== ea) $display("FAIL sync_awaddr[%0d]: got %h want %h", i, oa, ea); else passed++;
    end
    for (int i = 0; i < 2 * BL; i++) begin
      e = exp_w.pop_front(); o = 32'hDEADBEEF;
      if (obs_w.size() > 0) o = obs_w.pop_front();
      total++; if (o !== e) $display("FAIL sync_wdata[%0d]: got %h want %h", i, o, e); else passed++;
    end
  endtask

  task automatic test_enable_gate();
    int d0; bit ok; logic [31:0] e, o;
    clear_obs(); d0 = done_cnt; enable = 1;
    fill(BL - 1); tick(20);
    total++; if (obs_aw.size() != 0 || busy !== 1'b0) $display("FAIL gate_level15: got aw=%0d busy=%b want 0 0", obs_aw.size(), busy); else passed++;
    enable = 0; fill(1); tick(20);
    total++; if (obs_aw.size() != 0 || busy !== 1'b0) $display("FAIL gate_disabled: got aw=%0d busy=%b want 0 0", obs_aw.size(), busy); else passed++;
    exp_aw.push_back(28'h00); enable = 1;
    wait_done(d0 + 1, ok); tick(5);
    total++; if (ok !== 1'b1) $display("FAIL gate_timeout: got %0d want 1", ok); else passed++;
    total++; if (obs_aw.size() != 1 || obs_aw[0] !== exp_aw[0]) $display("FAIL gate_awaddr: got %p want %h", obs_aw, exp_aw[0]); else passed++;
    void'(exp_aw.pop_front());
    for (int i = 0; i < BL; i++) begin
      e = exp_w.pop_front(); o = 32'hDEADBEEF;
      if (obs_w.size() > 0) o = obs_w.pop_front();
      total++; if (o !== e) $display("FAIL gate_wdata[%0d]: got %h want %h", i, o, e); else passed++;
    end
  endtask

  task automatic test_resp_err();
    int d0; bit ok; logic [27:0] ea, oa;
    clear_obs(); d0 = done_cnt;
    total++; if (resp_err !== 1'b0) $display("FAIL err_initial: got %b want 0", resp_err); else passed++;
    bresp_val = 2'b10; exp_aw.push_back(28'h40); fill(BL);
    wait_done(d0 + 1, ok); tick(2);
    total++; if (resp_err !== 1'b1) $display("FAIL err_set: got %b want 1", resp_err); else passed++;
    bresp_val = 2'b00; exp_aw.push_back(28'h80); fill(BL);
    wait_done(d0 + 2, ok); tick(3);
    total++; if (ok !== 1'b1) $display("FAIL err_second_burst: got %0d want 1", ok); else passed++;
    total++; if (resp_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", resp_err); else passed++;
    for (int i = 0; i < 2; i++) begin
      ea = exp_aw.pop_front(); oa = 28'hFFFFFFF;
      if (obs_aw.size() > 0) oa = obs_aw.pop_front();
      total++; if (oa !== ea) $display("FAIL err_awaddr[%0d]: got %h want %h", i, oa, ea); else passed++;
    end
    exp_w.delete();
  endtask

  task automatic test_reset_mid_burst();
    int d0; bit ok, seen; logic [7:0] v; logic [31:0] e, o;
    clear_obs(); d0 = done_cnt;
    fill(BL);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin tick(1); seen = (obs_w.size() >= 7); end
    total++; if (seen !== 1'b1) $display("FAIL rst_mid_reach_beat7: got %0d want 1", seen); else passed++;
    total++; if (m_awaddr !== 28'h00) $display("FAIL rst_mid_pre_addr: got %h want 0", m_awaddr); else passed++;
    rst = 1; tick(1);
    v = {fifo_rd_en, m_awvalid, m_wvalid, m_wlast, m_bready, busy, burst_done, resp_err};
    total++; if (v !== 8'h00) $display("FAIL rst_mid_outputs: got %b want 00000000", v); else passed++;
    fifo_q.delete(); exp_w.delete(); exp_aw.delete();
    tick(2); rst = 0; clear_obs(); tick(2);
    total++; if (m_awaddr !== 28'h0) $display("FAIL rst_mid_awaddr: got %h want 0", m_awaddr); else passed++;
    // Move the pointer off BASE, then abandon a burst at 0x40.
    d0 = done_cnt; fill(BL);
    wait_done(d0 + 1, ok); tick(3);
    exp_w.delete(); clear_obs(); fill(BL);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin tick(1); seen = (obs_w.size() >= 7); end
    rst = 1; tick(1);
    total++; if (m_awaddr !== 28'h0) $display("FAIL rst_mid_base_addr: got %h want 0", m_awaddr); else passed++;
    fifo_q.delete(); exp_w.delete();
    tick(2); rst = 0; clear_obs(); tick(2);
    d0 = done_cnt; exp_aw.push_back(28'h0); fill(BL);
    wait_done(d0 + 1, ok); tick(5);
    total++; if (ok !== 1'b1) $display("FAIL rst_restart_timeout: got %0d want 1", ok); else passed++;
    total++; if (obs_aw.size() != 1 || obs_aw[0] !== exp_aw[0]) $display("FAIL rst_restart_awaddr: got %p want %h", obs_aw, exp_aw[0]); else passed++;
    for (int i = 0; i < BL; i++) begin
      e = exp_w.pop_front(); o = 32'hDEADBEEF;
      if (obs_w.size() > 0) o = obs_w.pop_front();
      total++; if (o !== e) $display("FAIL rst_restart_wdata[%0d]: got %h want %h", i, o, e); else passed++;
    end
    total++; if (underflow !== 0) $display("FAIL fifo_underflow: got %0d want 0", underflow); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_random_stall();
    test_wrap();
    test_frame_sync();
    test_enable_gate();
    test_resp_err();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
